// File: rtl/amb_sonuc_birimi_pkg.sv
// ---------------------------------------------------------------------------
// amb_sonuc_birimi_pkg
//   Shared types for the AMB result consumer:
//     dal_tip_e    - 3-bit branch type code carried with every AMB issue
//     etiket_t     - issue-time sideband {valid, rd, yaz} that travels
//                    alongside the AMB pipeline until the result is ready
//     dallanma_alindi_mi() - taken/not-taken decision from AMB compare flags
// ---------------------------------------------------------------------------
package amb_sonuc_birimi_pkg;

    typedef enum logic [2:0] {
        DAL_NONE = 3'd0,
        DAL_BEQ  = 3'd1,
        DAL_BNE  = 3'd2,
        DAL_BLT  = 3'd3,
        DAL_BGE  = 3'd4,
        DAL_BLTU = 3'd5,
        DAL_BGEU = 3'd6,
        DAL_JUMP = 3'd7
    } dal_tip_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       yaz;
    } etiket_t;

    localparam etiket_t ETIKET_BOS = '{valid: 1'b0, rd: 5'd0, yaz: 1'b0};

    // esit/buyuk describe rs1 relative to rs2, so "less than" is the case
    // where the operands are neither equal nor rs1 greater.
    function automatic logic dallanma_alindi_mi(
        input dal_tip_e tip,
        input logic     esit,
        input logic     buyuk,
        input logic     buyuk_u,
        input logic     jal_gecerli
    );
        logic sonuc;
        case (tip)
            DAL_BEQ:  sonuc = esit;
            DAL_BNE:  sonuc = !esit;
            DAL_BLT:  sonuc = !esit && !buyuk;
            DAL_BGE:  sonuc = esit || buyuk;
            DAL_BLTU: sonuc = !esit && !buyuk_u;
            DAL_BGEU: sonuc = esit || buyuk_u;
            DAL_JUMP: sonuc = jal_gecerli;
            default:  sonuc = 1'b0;
        endcase
        return sonuc;
    endfunction

endpackage

// File: rtl/amb_sonuc_birimi_if.sv
// ---------------------------------------------------------------------------
// amb_sonuc_birimi_if
//   Bundles every non-clock/reset signal of the AMB result consumer.
//   Signal suffixes are from the consumer's point of view.
//     issue side  : durdur_i, amb_aktif_i, hedef_yazmac_i, yaz_gecerli_i,
//                   dallanma_tipi_i, dallanma_adres_i, esit_mi_i,
//                   buyuk_mu_i, buyuk_mu_unsigned_i, jal_r_adres_i,
//                   jal_r_adres_gecerli_i
//     result side : amb_hazir_i, amb_sonuc_i
//     writeback   : yazmac_yaz_o, yazmac_adres_o, yazmac_veri_o
//     redirect    : pc_yonlendir_o, pc_hedef_o, boru_temizle_o,
//                   hizasiz_istisna_o
//   modport slave  - the consumer (amb_sonuc_birimi)
//   modport master - the AMB / pipeline side driving it
// ---------------------------------------------------------------------------
interface amb_sonuc_birimi_if;

    logic        durdur_i;
    logic        amb_aktif_i;
    logic [4:0]  hedef_yazmac_i;
    logic        yaz_gecerli_i;
    logic [2:0]  dallanma_tipi_i;
    logic [31:0] dallanma_adres_i;
    logic        esit_mi_i;
    logic        buyuk_mu_i;
    logic        buyuk_mu_unsigned_i;
    logic [31:0] jal_r_adres_i;
    logic        jal_r_adres_gecerli_i;
    logic        amb_hazir_i;
    logic [31:0] amb_sonuc_i;

    logic        yazmac_yaz_o;
    logic [4:0]  yazmac_adres_o;
    logic [31:0] yazmac_veri_o;
    logic        pc_yonlendir_o;
    logic [31:0] pc_hedef_o;
    logic        boru_temizle_o;
    logic        hizasiz_istisna_o;

    modport master (
        output durdur_i, amb_aktif_i, hedef_yazmac_i, yaz_gecerli_i,
               dallanma_tipi_i, dallanma_adres_i, esit_mi_i, buyuk_mu_i,
               buyuk_mu_unsigned_i, jal_r_adres_i, jal_r_adres_gecerli_i,
               amb_hazir_i, amb_sonuc_i,
        input  yazmac_yaz_o, yazmac_adres_o, yazmac_veri_o, pc_yonlendir_o,
               pc_hedef_o, boru_temizle_o, hizasiz_istisna_o
    );

    modport slave (
        input  durdur_i, amb_aktif_i, hedef_yazmac_i, yaz_gecerli_i,
               dallanma_tipi_i, dallanma_adres_i, esit_mi_i, buyuk_mu_i,
               buyuk_mu_unsigned_i, jal_r_adres_i, jal_r_adres_gecerli_i,
               amb_hazir_i, amb_sonuc_i,
        output yazmac_yaz_o, yazmac_adres_o, yazmac_veri_o, pc_yonlendir_o,
               pc_hedef_o, boru_temizle_o, hizasiz_istisna_o
    );

endinterface

// File: rtl/amb_sonuc_birimi_etiket_hatti.sv
// ---------------------------------------------------------------------------
// amb_sonuc_birimi_etiket_hatti
//   DERINLIK-deep shift register of issue tags that mirrors the AMB's fixed
//   issue->result latency, so the tail tag lines up with amb_hazir_i.
//   Ports:
//     clk_i, rst_i  clock, asynchronous active-low reset
//     advance_i     shift enable (pipeline not stalled)
//     push_i        an op is issued this cycle
//     squash_i      issued op is on the wrong path; push an invalid tag
//     etiket_i      tag of the issued op
//     kuyruk_o      tail tag, aligned with the AMB result
// ---------------------------------------------------------------------------
module amb_sonuc_birimi_etiket_hatti
    import amb_sonuc_birimi_pkg::*;
#(
    parameter int unsigned DERINLIK = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    advance_i,
    input  logic    push_i,
    input  logic    squash_i,
    input  etiket_t etiket_i,
    output etiket_t kuyruk_o
);

    etiket_t hat_q [DERINLIK];
    etiket_t hat_d [DERINLIK];

    // NOTE: hold-by-default first, then override; every path assigns hat_d,
    // so no latch is inferred.
    always_comb begin
        hat_d = hat_q;
        if (advance_i) begin
            // Cycles without an issue shift in a bubble to keep latency fixed.
            hat_d[0] = (push_i && !squash_i) ? etiket_i : ETIKET_BOS;
            for (int i = 1; i < DERINLIK; i++) begin
                hat_d[i] = hat_q[i-1];
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all stages shift
    // together. This array is only a few tags deep and its valid bits must be
    // cleared on reset, so resetting every entry is intended here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DERINLIK; i++) begin
                hat_q[i] <= ETIKET_BOS;
            end
        end else begin
            hat_q <= hat_d;
        end
    end

    assign kuyruk_o = hat_q[DERINLIK-1];

endmodule

// File: rtl/amb_sonuc_birimi.sv
// ---------------------------------------------------------------------------
// amb_sonuc_birimi
//   Consumer end of the AMB result interface (execute/writeback stage).
//   - Carries issue-time sideband (rd, write enable) alongside the AMB and
//     drives the register-file write when the result is ready.
//   - Resolves conditional branches and JAL/JALR at issue, then emits a
//     registered PC redirect pulse and holds the pipeline flush while the
//     wrong-path ops drain.
//   - Flags taken targets with bit 1 set as misaligned instead of
//     redirecting.
//   Parameters:
//     AMB_GECIKME     AMB issue->hazir latency in cycles (>=1)
//     TEMIZLE_CEVRIM  squash cycles that follow the redirect cycle (>=1)
//   Ports:
//     clk_i, rst_i     clock, asynchronous active-low reset
//     bus              amb_sonuc_birimi_if.slave (issue, result, writeback,
//                      redirect signals)
//     dallanma_sayisi_o, alinan_sayisi_o  resolved / taken branch counters,
//                      present only when DALLANMA_SAYAC_EN is defined
//   Build option: DALLANMA_SAYAC_EN enables the branch counters.
// ---------------------------------------------------------------------------
module amb_sonuc_birimi
    import amb_sonuc_birimi_pkg::*;
#(
    parameter int unsigned AMB_GECIKME    = 1,
    parameter int unsigned TEMIZLE_CEVRIM = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    amb_sonuc_birimi_if.slave bus
`ifdef DALLANMA_SAYAC_EN
    ,
    output logic [31:0]       dallanma_sayisi_o,
    output logic [31:0]       alinan_sayisi_o
`endif
);

    typedef enum logic [1:0] {
        BOS       = 2'd0,
        YONLENDIR = 2'd1,
        TEMIZLE   = 2'd2
    } durum_e;

    localparam int unsigned SAYAC_W = (TEMIZLE_CEVRIM > 1) ? $clog2(TEMIZLE_CEVRIM) : 1;
    localparam logic [SAYAC_W-1:0] SAYAC_BASLANGIC = SAYAC_W'(TEMIZLE_CEVRIM - 1);

    durum_e             durum_q, durum_d;
    logic [SAYAC_W-1:0] sayac_q, sayac_d;
    logic [31:0]        hedef_q, hedef_d;
    logic               hizasiz_q, hizasiz_d;

    dal_tip_e    tip;
    logic        ilerle;
    logic        yayin;
    logic        alindi;
    logic [31:0] hedef_adres;
    etiket_t     yeni_etiket;
    etiket_t     kuyruk_etiket;

    assign tip    = dal_tip_e'(bus.dallanma_tipi_i);
    assign ilerle = !bus.durdur_i;
    // Only issues seen in BOS are on the correct path and get resolved.
    assign yayin  = bus.amb_aktif_i && ilerle && (durum_q == BOS);
    assign alindi = dallanma_alindi_mi(tip, bus.esit_mi_i, bus.buyuk_mu_i,
                                       bus.buyuk_mu_unsigned_i,
                                       bus.jal_r_adres_gecerli_i);
    assign hedef_adres = (tip == DAL_JUMP) ? (bus.jal_r_adres_i & ~32'h1)
                                           : bus.dallanma_adres_i;

    // ---------------- redirect / flush FSM ----------------
    always_comb begin
        durum_d   = durum_q;
        sayac_d   = sayac_q;
        hedef_d   = hedef_q;
        hizasiz_d = hizasiz_q;
        // While stalled everything holds, so pending pulses replay on release.
        if (ilerle) begin
            hizasiz_d = 1'b0;
            case (durum_q)
                BOS: begin
                    if (yayin && alindi) begin
                        if (hedef_adres[1]) begin
                            hizasiz_d = 1'b1;
                        end else begin
                            durum_d = YONLENDIR;
                            hedef_d = hedef_adres;
                        end
                    end
                end
                YONLENDIR: begin
                    durum_d = TEMIZLE;
                    sayac_d = SAYAC_BASLANGIC;
                end
                TEMIZLE: begin
                    if (sayac_q == '0) begin
                        durum_d = BOS;
                    end else begin
                        sayac_d = sayac_q - SAYAC_W'(1);
                    end
                end
                default: durum_d = BOS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BOS;
            sayac_q   <= '0;
            hedef_q   <= '0;
            hizasiz_q <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            sayac_q   <= sayac_d;
            hedef_q   <= hedef_d;
            hizasiz_q <= hizasiz_d;
        end
    end

    assign bus.pc_yonlendir_o    = (durum_q == YONLENDIR) && ilerle;
    assign bus.pc_hedef_o        = hedef_q;
    assign bus.boru_temizle_o    = (durum_q != BOS);
    assign bus.hizasiz_istisna_o = hizasiz_q && ilerle;

    // ---------------- tag pipeline / writeback ----------------
    assign yeni_etiket = '{valid: 1'b1, rd: bus.hedef_yazmac_i, yaz: bus.yaz_gecerli_i};

    // Issues arriving outside BOS (including the redirect cycle) are squashed.
    amb_sonuc_birimi_etiket_hatti #(
        .DERINLIK (AMB_GECIKME)
    ) u_etiket_hatti (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (ilerle),
        .push_i    (bus.amb_aktif_i),
        .squash_i  (durum_q != BOS),
        .etiket_i  (yeni_etiket),
        .kuyruk_o  (kuyruk_etiket)
    );

    assign bus.yazmac_yaz_o   = bus.amb_hazir_i && ilerle && kuyruk_etiket.valid &&
                                kuyruk_etiket.yaz && (kuyruk_etiket.rd != 5'd0);
    assign bus.yazmac_adres_o = kuyruk_etiket.rd;
    assign bus.yazmac_veri_o  = bus.amb_sonuc_i;

    // ---------------- optional branch counters ----------------
`ifdef DALLANMA_SAYAC_EN
    logic [31:0] dallanma_sayisi_q, dallanma_sayisi_d;
    logic [31:0] alinan_sayisi_q, alinan_sayisi_d;

    always_comb begin
        dallanma_sayisi_d = dallanma_sayisi_q;
        alinan_sayisi_d   = alinan_sayisi_q;
        if (yayin && (tip != DAL_NONE)) begin
            dallanma_sayisi_d = dallanma_sayisi_q + 32'd1;
            if (alindi) begin
                alinan_sayisi_d = alinan_sayisi_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dallanma_sayisi_q <= '0;
            alinan_sayisi_q   <= '0;
        end else begin
            dallanma_sayisi_q <= dallanma_sayisi_d;
            alinan_sayisi_q   <= alinan_sayisi_d;
        end
    end

    assign dallanma_sayisi_o = dallanma_sayisi_q;
    assign alinan_sayisi_o   = alinan_sayisi_q;
`endif

endmodule
